// File: rtl/timer_pkg.sv
// Shared definitions for the BCD MM:SS countdown timer.
//   state_t      : timer FSM states, 2-bit encoding
//   DIGIT_W      : width of one BCD digit
//   BCD_MAX_ONES : largest value of a ones digit
package timer_pkg;

    localparam int              DIGIT_W      = 4;
    localparam logic [3:0]      BCD_MAX_ONES = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // True when a BCD digit is a legal value no larger than max_val.
    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d,
                                      input logic [DIGIT_W-1:0] max_val);
        return (d <= BCD_MAX_ONES) && (d <= max_val);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load.
//   clk, rst   : clock, async active-low reset (digit -> 0)
//   load       : load load_digit (takes priority over dec_en)
//   load_digit : value to load
//   dec_en     : decrement this digit (borrow in from the digit below)
//   digit      : current digit value
//   borrow_out : decrementing from 0; wraps to MAX and borrows upward
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX_ONES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] r_digit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_digit <= '0;
        else if (load)
            r_digit <= load_digit;
        else if (dec_en)
            r_digit <= (r_digit == '0) ? MAX : r_digit - 1'b1;
    end

    assign digit      = r_digit;
    assign borrow_out = dec_en & (r_digit == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD MM:SS countdown timer.
//   clk, rst   : clock, async active-low reset
//   tick       : 1 Hz decrement strobe
//   load       : load load_val (ignored while running)
//   load_val   : BCD {min_tens, min_ones, sec_tens, sec_ones}
//   start      : begin / resume counting
//   pause      : suspend counting
//   count      : current BCD value, same packing as load_val
//   running    : in RUN
//   done       : in DONE (level)
//   done_pulse : one cycle on entry to DONE
//   load_err   : one cycle when an out-of-range load is rejected
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] count,
    output logic        running,
    output logic        done,
    output logic        done_pulse,
    output logic        load_err
);

    state_t      r_state, w_next;
    logic        r_done_pulse;
    logic        r_load_err;
    logic [15:0] w_count;
    logic [4:0]  w_chain;      // decrement enable into digit i, borrow out of digit 3
    logic        w_load_seen;  // load request in a state that listens to it
    logic        w_load_valid;
    logic        w_load_apply;
    logic        w_dec;
    logic        w_count_zero;

    assign w_load_valid = digit_ok(load_val[3:0],   BCD_MAX_ONES)
                        & digit_ok(load_val[7:4],   DIGIT_W'(SEC_TENS_MAX))
                        & digit_ok(load_val[11:8],  BCD_MAX_ONES)
                        & digit_ok(load_val[15:12], DIGIT_W'(MIN_TENS_MAX));

    assign w_load_seen  = load & (r_state != RUN);
    assign w_load_apply = w_load_seen & w_load_valid;
    assign w_dec        = (r_state == RUN) & tick & ~pause;
    assign w_count_zero = (w_count == 16'h0000);

    // Digit i: 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
    assign w_chain[0] = w_dec;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [DIGIT_W-1:0] DMAX =
                (gi == 1) ? DIGIT_W'(SEC_TENS_MAX) :
                (gi == 3) ? DIGIT_W'(MIN_TENS_MAX) : BCD_MAX_ONES;
            bcd_down_digit #(.MAX(DMAX)) u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (w_load_apply),
                .load_digit (load_val[gi*DIGIT_W +: DIGIT_W]),
                .dec_en     (w_chain[gi]),
                .digit      (w_count[gi*DIGIT_W +: DIGIT_W]),
                .borrow_out (w_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_done_pulse <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_done_pulse <= (r_state != DONE) & (w_next == DONE);
            r_load_err   <= w_load_seen & ~w_load_valid;
        end
    end

    // Any load request (valid or not) outside RUN masks start that cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_load_seen && start)
                    w_next = w_count_zero ? DONE : RUN;
            end
            RUN: begin
                // w_chain[4] only fires on an underflow from 00:00, which the
                // start guards make unreachable; treat it as done regardless.
                if (pause)
                    w_next = PAUSE;
                else if (w_dec && (w_count == 16'h0001 || w_chain[4]))
                    w_next = DONE;
            end
            PAUSE: begin
                if (!w_load_seen && start && !w_count_zero)
                    w_next = RUN;
            end
            DONE: begin
                if (w_load_apply)
                    w_next = IDLE;
                else if (!w_load_seen && start)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign count      = w_count;
    assign running    = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign done_pulse = r_done_pulse;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        done_pulse;
    logic        load_err;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_countdown_timer #(.MIN_TENS_MAX(5), .SEC_TENS_MAX(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; inputs drop afterwards, sample 1 ns past the edge.
    task automatic cyc(input logic t, input logic l, input logic [15:0] lv,
                       input logic s, input logic p);
        tick = t; load = l; load_val = lv; start = s; pause = p;
        @(posedge clk);
        #1;
        tick = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic chk_st(input string tag, input logic [15:0] c, input logic r,
                          input logic d, input logic dp, input logic le);
        chk({tag, ".count"},      32'(count),      32'(c));
        chk({tag, ".running"},    32'(running),    32'(r));
        chk({tag, ".done"},       32'(done),       32'(d));
        chk({tag, ".done_pulse"}, 32'(done_pulse), 32'(dp));
        chk({tag, ".load_err"},   32'(load_err),   32'(le));
    endtask

    initial begin
        #3;
        chk_st("reset", 16'h0000, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 00:03 countdown to done
        cyc(0, 1, 16'h0003, 0, 0);  chk_st("ld3",   16'h0003, 0, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("st3",   16'h0003, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t3a",   16'h0002, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t3b",   16'h0001, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t3c",   16'h0000, 0, 1, 1, 0);
        cyc(0, 0, 16'h0000, 0, 0);  chk_st("hold3", 16'h0000, 0, 1, 0, 0);

        // Full borrow chain 10:00 -> 09:59
        cyc(0, 1, 16'h1000, 0, 0);  chk_st("ld1000", 16'h1000, 0, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("st1000", 16'h1000, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("brw",    16'h0959, 1, 0, 0, 0);

        // Load ignored while running, no load_err
        cyc(0, 1, 16'h0500, 0, 0);  chk_st("ldrun",  16'h0959, 1, 0, 0, 0);

        // Pause / resume
        cyc(0, 0, 16'h0000, 0, 1);  chk_st("pz0",    16'h0959, 0, 0, 0, 0);
        cyc(0, 1, 16'h0500, 0, 0);  chk_st("ld500",  16'h0500, 0, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("st500",  16'h0500, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t459",   16'h0459, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t458",   16'h0458, 1, 0, 0, 0);
        cyc(0, 0, 16'h0000, 0, 1);  chk_st("pz1",    16'h0458, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'h0000, 0, 0);  chk_st("pzhold", 16'h0458, 0, 0, 0, 0);
        end
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("resume", 16'h0458, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t457",   16'h0457, 1, 0, 0, 0);

        // Pause and tick together: pause wins, no decrement
        cyc(1, 0, 16'h0000, 0, 1);  chk_st("pztick", 16'h0457, 0, 0, 0, 0);

        // Async reset mid-run at 01:30, between edges
        cyc(0, 1, 16'h0130, 0, 0);  chk_st("ld130",  16'h0130, 0, 0, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("st130",  16'h0130, 1, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk_st("arst", 16'h0000, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_st("arsthold", 16'h0000, 0, 0, 0, 0);
        rst = 1'b1;

        // Load validation in IDLE
        cyc(0, 1, 16'h0070, 0, 0);  chk_st("bad70",  16'h0000, 0, 0, 0, 1);
        cyc(0, 0, 16'h0000, 0, 0);  chk_st("bad70b", 16'h0000, 0, 0, 0, 0);
        cyc(0, 1, 16'h0A00, 0, 0);  chk_st("bad0A",  16'h0000, 0, 0, 0, 1);
        cyc(0, 1, 16'h6000, 0, 0);  chk_st("bad60",  16'h0000, 0, 0, 0, 1);
        cyc(0, 1, 16'h5959, 0, 0);  chk_st("ok5959", 16'h5959, 0, 0, 0, 0);

        // Load wins over start in the same cycle
        cyc(0, 1, 16'h0000, 1, 0);  chk_st("ldst0",  16'h0000, 0, 0, 0, 0);
        // Start at 00:00 -> DONE directly, one done_pulse
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("st0",    16'h0000, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 16'h0000, 0, 0);  chk_st("dnhold", 16'h0000, 0, 1, 0, 0);
        end

        // Invalid load in DONE: no state change
        cyc(0, 1, 16'h00F0, 0, 0);  chk_st("baddn",  16'h0000, 0, 1, 0, 1);
        // Valid load from DONE -> IDLE
        cyc(0, 1, 16'h0002, 0, 0);  chk_st("lddn",   16'h0002, 0, 0, 0, 0);
        // Start with tick in IDLE: run, no decrement
        cyc(1, 0, 16'h0000, 1, 0);  chk_st("sttick", 16'h0002, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t1",     16'h0001, 1, 0, 0, 0);
        cyc(1, 0, 16'h0000, 0, 0);  chk_st("t0",     16'h0000, 0, 1, 1, 0);
        // Start in DONE -> IDLE
        cyc(0, 0, 16'h0000, 1, 0);  chk_st("dnst",   16'h0000, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
